// File: rtl/excitation_source_if.sv
`default_nettype none
// ============================================================================
// Module  : excitation_source_if
// Purpose : Hand-off bus between the excitation source and the all-pole
//           filter: the held sample, its start pulse and the filter's done.
// Rev     : 1.0  initial release
// ============================================================================
interface excitation_source_if;
  logic [15:0] sig_out;    // signed excitation sample
  logic        start;      // one-cycle start pulse to the filter
  logic        filt_done;  // filter idle / ready

  // Excitation source side
  modport master (
    output sig_out,
    output start,
    input  filt_done
  );

  // Filter side
  modport slave (
    input  sig_out,
    input  start,
    output filt_done
  );
endinterface
`default_nettype wire

// File: rtl/excitation_source.sv
`default_nettype none
// ============================================================================
// Module  : excitation_source
// Purpose : Produces one excitation sample per accepted sample strobe, either
//           a voiced pulse train or unvoiced LFSR noise scaled by amplitude,
//           holds it on the filter input and issues a start pulse once the
//           filter reports done.
// Rev     : 1.0  initial release
// ============================================================================
module excitation_source #(
  parameter logic [16:0] LFSR_SEED = 17'h00001
) (
  input  wire logic        clk,
  input  wire logic        rst_an,
  input  wire logic [7:0]  period,
  input  wire logic [7:0]  amp,
  input  wire logic        ld_params,
  input  wire logic        sample_tick,
  output      logic        overrun,
  excitation_source_if.master bus
);

  // A zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [16:0] C_SEED = (LFSR_SEED == 17'h0) ? 17'h00001 : LFSR_SEED;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q,      state_d;
  logic [15:0] sig_out_q,    sig_out_d;
  logic        start_q,      start_d;
  logic        overrun_q,    overrun_d;
  logic [7:0]  sh_period_q,  sh_period_d;
  logic [7:0]  sh_amp_q,     sh_amp_d;
  logic [7:0]  act_period_q, act_period_d;
  logic [7:0]  act_amp_q,    act_amp_d;
  logic [7:0]  cnt_q,        cnt_d;
  logic [16:0] lfsr_q,       lfsr_d;

  // Parameters that an accepted tick in this cycle would use; a same-cycle
  // load wins over the shadow contents.
  logic [7:0]  w_new_period;
  logic [7:0]  w_new_amp;
  logic [7:0]  w_cnt_eff;
  logic [16:0] w_lfsr_next;
  logic [15:0] w_voiced_amp;
  logic [15:0] w_noise_amp;
  logic        w_accept;

  // Datapath helpers: candidate parameters, next LFSR value, scaled amplitudes.
  always_comb begin
    w_new_period = ld_params ? period : sh_period_q;
    w_new_amp    = ld_params ? amp    : sh_amp_q;
    // Coming out of noise mode the countdown restarts so the first voiced
    // sample is a pulse.
    w_cnt_eff    = (act_period_q == 8'd0) ? 8'd0 : cnt_q;
    w_lfsr_next  = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
    w_voiced_amp = {1'b0, w_new_amp, 7'b0};
    w_noise_amp  = {2'b0, w_new_amp, 6'b0};
    // A tick is taken only when idle and not in the cycle the start pulse
    // is being presented.
    w_accept     = (state_q == S_IDLE) && sample_tick && !start_q;
  end

  // Next-state and output logic for the hand-off FSM and sample generator.
  always_comb begin
    state_d      = state_q;
    sig_out_d    = sig_out_q;
    start_d      = 1'b0;
    overrun_d    = overrun_q;
    sh_period_d  = w_new_period;
    sh_amp_d     = w_new_amp;
    act_period_d = act_period_q;
    act_amp_d    = act_amp_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;

    if (sample_tick && !w_accept) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          act_period_d = w_new_period;
          act_amp_d    = w_new_amp;
          state_d      = S_WAIT;
          if (w_new_period == 8'd0) begin
            lfsr_d    = w_lfsr_next;
            sig_out_d = w_lfsr_next[0] ? w_noise_amp : (16'd0 - w_noise_amp);
          end else if (w_cnt_eff == 8'd0) begin
            sig_out_d = w_voiced_amp;
            cnt_d     = w_new_period - 8'd1;
          end else begin
            sig_out_d = 16'd0;
            cnt_d     = w_cnt_eff - 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (bus.filt_done) begin
          start_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q      <= S_IDLE;
      sig_out_q    <= 16'd0;
      start_q      <= 1'b0;
      overrun_q    <= 1'b0;
      sh_period_q  <= 8'd0;
      sh_amp_q     <= 8'd0;
      act_period_q <= 8'd0;
      act_amp_q    <= 8'd0;
      cnt_q        <= 8'd0;
      lfsr_q       <= C_SEED;
    end else begin
      state_q      <= state_d;
      sig_out_q    <= sig_out_d;
      start_q      <= start_d;
      overrun_q    <= overrun_d;
      sh_period_q  <= sh_period_d;
      sh_amp_q     <= sh_amp_d;
      act_period_q <= act_period_d;
      act_amp_q    <= act_amp_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
    end
  end

  assign bus.sig_out = sig_out_q;
  assign bus.start   = start_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: doc/excitation_source.md
Name: excitation_source

Overview:
- Upstream stage of the 12th-order all-pole filter.
- Once per sample strobe, generates one excitation sample: a voiced pulse train or unvoiced LFSR noise, scaled by amplitude.
- Drives the filter's 16-bit signed input and its start pulse, gated by the filter's done.
- Holds the sample stable until the next sample, because the filter reads its input several cycles after start.

Parameters:
- LFSR_SEED, 17'h00001: noise LFSR reset/seed value. Must be nonzero; a zero value is replaced by 17'h00001.

Ports:
- clk  input  1  system clock
- rst_an  input  1  reset, asynchronous, active-low
- period  input  8  pitch period in samples; 0 selects unvoiced noise
- amp  input  8  unsigned excitation amplitude
- ld_params  input  1  one-cycle pulse: latch period/amp into shadow registers
- sample_tick  input  1  one-cycle sample-rate strobe (10 kHz nominal)
- filt_done  input  1  filter idle/ready (filter done output)
- sig_out  output  16  signed excitation sample to filter sig_in
- start  output  1  one-cycle registered pulse to filter start
- overrun  output  1  sticky: tick arrived while previous sample not yet handed off

Behaviour:
- Reset values (async, immediate):
  - sig_out=0, start=0, overrun=0
  - shadow and active period/amp = 0, pitch counter = 0, lfsr = LFSR_SEED
  - FSM = S_IDLE
- Reset mid-operation aborts any pending hand-off; no start is issued afterwards.
- Parameter load:
  - ld_params copies period/amp into shadow registers at any time and in any state.
  - Shadow is copied to the active registers only when a tick is accepted, before the sample is computed.
  - If ld_params and an accepted tick occur in the same cycle, the new inputs are used for that sample.
- FSM states: S_IDLE, S_WAIT.
- S_IDLE, sample_tick=1 (accepted tick, cycle T):
  - Update active params and compute the sample; register sig_out at T+1.
  - Go to S_WAIT.
- S_WAIT, filt_done=1:
  - start=1 in the next cycle, exactly one cycle.
  - Return to S_IDLE in that same cycle.
  - Minimum latency: tick at T, sig_out at T+1, start at T+2.
- S_WAIT, filt_done=0: stay in S_WAIT; sig_out holds.
- Tick arriving while in S_WAIT (or coincident with start=1): tick dropped, overrun set to 1. overrun is cleared only by reset.
- sig_out changes only on an accepted tick; it is stable between consecutive accepted ticks.
- Voiced (active period != 0):
  - If pitch counter == 0: sig_out = +amp*128 (zero-extended amp, shifted left 7; max 32640), then counter <= period-1.
  - Otherwise: sig_out = 0, counter decrements.
  - On an unvoiced-to-voiced change (previous active period == 0), counter is forced to 0, so the first voiced sample is a pulse.
  - period=1 gives a pulse every sample.
  - A new period takes effect at the next reload only; the running countdown is not truncated.
- Unvoiced (active period == 0):
  - LFSR advances exactly once per accepted tick: 17-bit Fibonacci, fb = lfsr[16]^lfsr[13], lfsr <= {lfsr[15:0], fb}.
  - sig_out = new lfsr[0] ? +amp*64 : -amp*64 (two's complement, 16 bit).
  - LFSR does not advance in voiced mode or on dropped ticks.
- amp=0 yields sig_out=0 in both modes, but start is still issued per sample.

Test Plan:
- Reset, ld_params period=3 amp=100, 7 ticks spaced 40 cycles, filt_done=1 → sig_out = 12800, 0, 0, 12800, 0, 0, 12800; one start per tick, 2 cycles after tick.
- Reset (seed 1), ld_params period=0 amp=10, 14 ticks → samples 1–13 = -640, sample 14 = +640; exactly 14 start pulses.
- Hold filt_done=0 for 20 cycles after a tick → start stays 0, sig_out stable; filt_done=1 at cycle 20 → single start pulse next cycle.
- Second tick while in S_WAIT → overrun=1 and stays 1; sig_out unchanged, no extra start, LFSR/counter not advanced.
- Mid-countdown (period=5) ld_params period=2 → remaining zeros of the 5-period complete, then pulses every 2 samples; switching period 0 → 4 gives an immediate pulse on the next tick.
- Assert rst_an low while in S_WAIT → sig_out=0, start=0, overrun=0 immediately; no start after release until a new tick.
